// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
//   vend_state_t  : controller state encoding
//   COIN_*_VAL    : accepted coin denominations
//   price_slice() : extracts one item price from the packed price vector
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } vend_state_t;

  localparam int COIN_5_VAL  = 5;
  localparam int COIN_10_VAL = 10;
  localparam int COIN_50_VAL = 50;

  // Up to 8 items of up to 32 bits each.
  localparam int PRICE_BITS = 256;

  function automatic logic [31:0] price_slice(input logic [PRICE_BITS-1:0] prices,
                                              input int idx, input int w);
    logic [PRICE_BITS-1:0] sh;
    logic [31:0]           mask;
    sh   = prices >> (idx * w);
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/vend_ctrl_param_if.sv
// Key/coin inputs and display-side outputs of the vending controller.
//   master : drives cancel/coin_*/sel, observes the rest (key/coin front end)
//   slave  : the controller itself
interface vend_ctrl_param_if #(
  parameter int NUM_ITEMS = 3,
  parameter int CREDIT_W  = 8
);
  logic                 cancel;
  logic                 coin_5;
  logic                 coin_10;
  logic                 coin_50;
  logic [NUM_ITEMS-1:0] sel;
  logic [NUM_ITEMS-1:0] avail;
  logic [NUM_ITEMS-1:0] vend;
  logic                 change_out;
  logic                 coin_reject;
  logic [CREDIT_W-1:0]  credit;
  logic                 busy;

  modport master (
    output cancel, coin_5, coin_10, coin_50, sel,
    input  avail, vend, change_out, coin_reject, credit, busy
  );

  modport slave (
    input  cancel, coin_5, coin_10, coin_50, sel,
    output avail, vend, change_out, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_change_timer.sv
// Paces change pulses: down-counter reloaded with GAP-1 on load and after
// each tick; tick fires while enabled and the count has reached zero.
//   clk, rst_n : clock, async active-low reset
//   load       : (re)start the gap from the top
//   en         : count while in the change state
//   tick       : one change coin may be released this cycle
module vend_change_timer #(
  parameter int GAP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(GAP - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: credit accumulation with a ceiling,
// per-item pricing, single-cycle vend and paced change return.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of vend_ctrl_param_if (keys/coins in,
//                avail/vend/change_out/coin_reject/credit/busy out)
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | accepting coins, keys and cancel
// ST_VEND   | one cycle, vend[i] high, price already deducted
// ST_CHANGE | paying credit back one COIN_UNIT per timer tick
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int                          NUM_ITEMS  = 3,
  parameter int                          CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES   = {8'd25, 8'd20, 8'd15},
  parameter int                          MAX_CREDIT = 50,
  parameter int                          COIN_UNIT  = 5,
  parameter int                          CHANGE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vend_ctrl_param_if.slave  bus
);
  localparam int CW1 = CREDIT_W + 1;
  localparam int IW  = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  vend_state_t           state;
  logic [CREDIT_W-1:0]   credit_q;
  logic [NUM_ITEMS-1:0]  vend_q;
  logic                  change_q;
  logic                  reject_q;

  logic [CREDIT_W-1:0]   price [NUM_ITEMS];
  logic [NUM_ITEMS-1:0]  avail_c;
  logic                  coin_any;
  logic [CW1-1:0]        coin_val;
  logic [CW1-1:0]        credit_sum;
  logic                  coin_fits;
  logic                  sel_any;
  logic [IW-1:0]         sel_idx;
  logic [CREDIT_W-1:0]   sel_price;
  logic                  tmr_load;
  logic                  tmr_tick;

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
    assign price[g] = CREDIT_W'(price_slice(PRICE_BITS'(PRICES), g, CREDIT_W));
  end

  // Only the highest denomination counts when several coins arrive together.
  always_comb begin
    coin_val = '0;
    if (bus.coin_50)      coin_val = CW1'(COIN_50_VAL);
    else if (bus.coin_10) coin_val = CW1'(COIN_10_VAL);
    else if (bus.coin_5)  coin_val = CW1'(COIN_5_VAL);
  end

  assign coin_any   = bus.coin_5 || bus.coin_10 || bus.coin_50;
  assign credit_sum = {1'b0, credit_q} + coin_val;
  assign coin_fits  = credit_sum <= CW1'(MAX_CREDIT);

  // Lowest-index key wins.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (bus.sel[i]) begin
        sel_any = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign sel_price = price[sel_idx];

  always_comb begin
    avail_c = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_c[i] = (state == ST_IDLE) && (credit_q >= price[i]);
    end
  end

  // Restart the gap on every entry into ST_CHANGE.
  assign tmr_load = ((state == ST_IDLE) && bus.cancel && (credit_q != '0)) ||
                    ((state == ST_VEND) && (credit_q != '0));

  vend_change_timer #(.GAP(CHANGE_GAP)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (state == ST_CHANGE),
    .tick  (tmr_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      credit_q <= '0;
      vend_q   <= '0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      vend_q   <= '0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cancel) begin
            if (credit_q != '0) state <= ST_CHANGE;
          end else if (coin_any) begin
            if (coin_fits) credit_q <= credit_sum[CREDIT_W-1:0];
            else           reject_q <= 1'b1;
          end else if (sel_any && (credit_q >= sel_price)) begin
            state    <= ST_VEND;
            credit_q <= credit_q - sel_price;
            vend_q   <= NUM_ITEMS'(1) << sel_idx;
          end
        end
        ST_VEND: begin
          reject_q <= coin_any;
          state    <= (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        end
        ST_CHANGE: begin
          reject_q <= coin_any;
          if (credit_q == '0) begin
            state <= ST_IDLE;
          end else if (tmr_tick) begin
            change_q <= 1'b1;
            // Leave as the last coin goes out so busy drops with it.
            if (credit_q <= CREDIT_W'(COIN_UNIT)) begin
              credit_q <= '0;
              state    <= ST_IDLE;
            end else begin
              credit_q <= credit_q - CREDIT_W'(COIN_UNIT);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.avail       = avail_c;
  assign bus.vend        = vend_q;
  assign bus.change_out  = change_q;
  assign bus.coin_reject = reject_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = (state != ST_IDLE);
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench for vend_ctrl_param: stimulus pushes the expected
// vend/change/reject events, a monitor pops them as the DUT pulses.
module tb_vend_ctrl_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vend_ctrl_param_if #(.NUM_ITEMS(3), .CREDIT_W(8)) bus ();

  vend_ctrl_param #(
    .NUM_ITEMS (3),
    .CREDIT_W  (8),
    .PRICES    ({8'd25, 8'd20, 8'd15}),
    .MAX_CREDIT(50),
    .COIN_UNIT (5),
    .CHANGE_GAP(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [2:0] vend;
    logic       chg;
    logic       rej;
    logic [7:0] credit;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] v, input logic c, input logic r, input logic [7:0] cr);
    ev_t e;
    e.vend = v; e.chg = c; e.rej = r; e.credit = cr;
    sb.push_back(e);
  endtask

  task automatic push_changes(input int from_credit);
    for (int c = from_credit - 5; c >= 0; c -= 5) push(3'b000, 1'b1, 1'b0, 8'(c));
  endtask

  task automatic coins(input logic c5, input logic c10, input logic c50);
    bus.coin_5 = c5; bus.coin_10 = c10; bus.coin_50 = c50;
    @(negedge clk);
    bus.coin_5 = 1'b0; bus.coin_10 = 1'b0; bus.coin_50 = 1'b0;
  endtask

  task automatic press(input logic [2:0] s);
    bus.sel = s;
    @(negedge clk);
    bus.sel = '0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (!bus.busy && sb.size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    check({name, "_idle_timeout"}, 32'(done), 32'd1);
  endtask

  // Monitor: every DUT pulse must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (bus.vend != '0 || bus.change_out || bus.coin_reject)) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: vend=%b chg=%b rej=%b credit=%0d, none expected",
                   bus.vend, bus.change_out, bus.coin_reject, bus.credit);
        end else begin
          ev_t e;
          e = sb.pop_front();
          if (bus.vend !== e.vend || bus.change_out !== e.chg ||
              bus.coin_reject !== e.rej || bus.credit !== e.credit) begin
            n_fail++;
            $display("FAIL event: got vend=%b chg=%b rej=%b credit=%0d, expected vend=%b chg=%b rej=%b credit=%0d",
                     bus.vend, bus.change_out, bus.coin_reject, bus.credit,
                     e.vend, e.chg, e.rej, e.credit);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.cancel = 1'b0; bus.coin_5 = 1'b0; bus.coin_10 = 1'b0; bus.coin_50 = 1'b0;
    bus.sel = '0;
    repeat (3) @(negedge clk);
    check("rst_credit", 32'(bus.credit), 32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_avail",  32'(bus.avail),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 10+10, buy item0 (15): vend with 5 left, one change coin
    coins(0, 1, 0);
    coins(0, 1, 0);
    check("c1_credit", 32'(bus.credit), 32'd20);
    check("c1_avail",  32'(bus.avail),  32'b011);
    push(3'b001, 1'b0, 1'b0, 8'd5);
    push_changes(5);
    press(3'b001);
    wait_idle("c1");
    check("c1_credit_end", 32'(bus.credit), 32'd0);

    // 50 reaches the cap, extra 5 rejected
    coins(0, 0, 1);
    check("c2_credit", 32'(bus.credit), 32'd50);
    check("c2_avail",  32'(bus.avail),  32'b111);
    push(3'b000, 1'b0, 1'b1, 8'd50);
    coins(1, 0, 0);
    check("c2_credit_after_reject", 32'(bus.credit), 32'd50);
    push_changes(50);
    do_cancel();
    wait_idle("c2");

    // all three coins together: only the 50 counts
    coins(1, 1, 1);
    check("c3_credit", 32'(bus.credit), 32'd50);
    push(3'b100, 1'b0, 1'b0, 8'd25);
    push_changes(25);
    press(3'b100);
    wait_idle("c3");

    // credit 25, cancel: five change pulses two cycles apart
    coins(0, 1, 0);
    coins(0, 1, 0);
    coins(1, 0, 0);
    check("c4_credit", 32'(bus.credit), 32'd25);
    push_changes(25);
    do_cancel();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("c4_change_k%0d", k), 32'(bus.change_out), 32'((k % 2) == 0));
      check($sformatf("c4_busy_k%0d", k),   32'(bus.busy),       32'(k < 10));
      if (k == 1) check("c4_avail_in_change", 32'(bus.avail), 32'd0);
    end
    check("c4_credit_end", 32'(bus.credit), 32'd0);

    // unaffordable key ignored, then sel=110 at credit 20 vends item1
    coins(0, 1, 0);
    press(3'b001);
    check("c5_ignored_credit", 32'(bus.credit), 32'd10);
    check("c5_ignored_busy",   32'(bus.busy),   32'd0);
    coins(0, 1, 0);
    push(3'b010, 1'b0, 1'b0, 8'd0);
    press(3'b110);
    check("c5_busy_vend", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("c5_busy_after", 32'(bus.busy),   32'd0);
    check("c5_credit",     32'(bus.credit), 32'd0);

    // credit 15, cancel, coin rejected in CHANGE, then reset mid-change
    coins(0, 1, 0);
    coins(1, 0, 0);
    check("c6_credit", 32'(bus.credit), 32'd15);
    do_cancel();
    push(3'b000, 1'b0, 1'b1, 8'd15);
    coins(1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("c6_rst_credit", 32'(bus.credit),     32'd0);
    check("c6_rst_busy",   32'(bus.busy),       32'd0);
    check("c6_rst_change", 32'(bus.change_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("c6_credit_end", 32'(bus.credit), 32'd0);
    check("c6_busy_end",   32'(bus.busy),   32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
